// File: rtl/delta_decoder_if.sv
// Handshake bundle for the delta decoder: input beat (seed or signed delta)
// and the registered reconstructed-sample output stage.
interface delta_decoder_if #(
    parameter int DW = 8,
    parameter int IW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic          in_load;
    logic [DW-1:0] in_seed;
    logic          in_sign;
    logic [DW:0]   in_mag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sat;
    logic [IW-1:0] out_idx;
    logic          err_noseed;

    modport master (
        output in_valid, in_load, in_seed, in_sign, in_mag, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_idx, err_noseed
    );

    modport slave (
        input  in_valid, in_load, in_seed, in_sign, in_mag, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_idx, err_noseed
    );
endinterface

// File: rtl/delta_decoder.sv
// Rebuilds absolute samples from sign/magnitude deltas with saturation,
// presented through a one-deep registered valid/ready output stage.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no seed seen since reset; delta beats are dropped and flagged
// ST_RUN  | accumulator seeded; delta beats produce clamped samples
module delta_decoder #(
    parameter int DW = 8,
    parameter int IW = 8
) (
    input  logic            clk,
    input  logic            rst,
    delta_decoder_if.slave  bus
);
    // Three guard bits: acc (DW) + mag (DW+1) can reach 3*2^DW-2, which a
    // DW+2-bit signed value cannot hold.
    localparam int TW = DW + 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [DW-1:0] r_acc;
    logic [DW-1:0] w_acc_nxt;
    logic          r_out_valid;
    logic          w_out_valid_nxt;
    logic [DW-1:0] r_out_data;
    logic [DW-1:0] w_out_data_nxt;
    logic          r_out_sat;
    logic          w_out_sat_nxt;
    logic [IW-1:0] r_out_idx;
    logic [IW-1:0] w_out_idx_nxt;
    logic          r_err_noseed;
    logic          w_err_noseed_nxt;

    logic          w_in_ready;
    logic          w_accept;
    logic [TW-1:0] w_acc_ext;
    logic [TW-1:0] w_mag_ext;
    logic [TW-1:0] w_sum;
    logic          w_neg;
    logic          w_over;
    logic [DW-1:0] w_clamped;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Two's-complement sum in TW bits; the top bit is the sign.
    assign w_acc_ext = {3'b000, r_acc};
    assign w_mag_ext = {2'b00, bus.in_mag};
    assign w_sum     = bus.in_sign ? (w_acc_ext - w_mag_ext) : (w_acc_ext + w_mag_ext);
    assign w_neg     = w_sum[TW-1];
    assign w_over    = !w_neg && (|w_sum[TW-2:DW]);

    always_comb begin
        w_clamped = w_sum[DW-1:0];
        if (w_neg) begin
            w_clamped = '0;
        end else if (w_over) begin
            w_clamped = '1;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_acc_nxt        = r_acc;
        w_out_data_nxt   = r_out_data;
        w_out_sat_nxt    = r_out_sat;
        w_out_idx_nxt    = r_out_idx;
        w_err_noseed_nxt = 1'b0;
        w_out_valid_nxt  = r_out_valid && !bus.out_ready;

        if (w_accept) begin
            if (bus.in_load) begin
                w_state_nxt     = ST_RUN;
                w_acc_nxt       = bus.in_seed;
                w_out_data_nxt  = bus.in_seed;
                w_out_sat_nxt   = 1'b0;
                w_out_idx_nxt   = '0;
                w_out_valid_nxt = 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_err_noseed_nxt = 1'b1;
                    end
                    ST_RUN: begin
                        w_acc_nxt       = w_clamped;
                        w_out_data_nxt  = w_clamped;
                        w_out_sat_nxt   = w_neg || w_over;
                        w_out_idx_nxt   = r_out_idx + 1'b1;
                        w_out_valid_nxt = 1'b1;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sat    <= 1'b0;
            r_out_idx    <= '0;
            r_err_noseed <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_sat    <= w_out_sat_nxt;
            r_out_idx    <= w_out_idx_nxt;
            r_err_noseed <= w_err_noseed_nxt;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_sat    = r_out_sat;
    assign bus.out_idx    = r_out_idx;
    assign bus.err_noseed = r_err_noseed;
endmodule

// File: tb/tb_delta_decoder.sv
// Directed bench for delta_decoder: vector table for the cycle-by-cycle
// behaviour plus hand sequences for index wrap and reset mid-stream.
module tb_delta_decoder;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    delta_decoder_if #(.DW(8), .IW(8)) bus ();

    delta_decoder #(.DW(8), .IW(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       v;
        logic       ld;
        logic [7:0] seed;
        logic       sg;
        logic [8:0] mag;
        logic       ordy;
        logic       e_rdy;
        logic       e_ov;
        logic [7:0] e_data;
        logic       e_sat;
        logic [7:0] e_idx;
        logic       e_err;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(logic v, logic ld, logic [7:0] seed, logic sg,
                                logic [8:0] mag, logic ordy, logic e_rdy,
                                logic e_ov, logic [7:0] e_data, logic e_sat,
                                logic [7:0] e_idx, logic e_err);
        vec_t r;
        r.v = v; r.ld = ld; r.seed = seed; r.sg = sg; r.mag = mag; r.ordy = ordy;
        r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_data = e_data; r.e_sat = e_sat;
        r.e_idx = e_idx; r.e_err = e_err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic [7:0] seed,
                         input logic sg, input logic [8:0] mag, input logic ordy);
        bus.in_valid  = v;
        bus.in_load   = ld;
        bus.in_seed   = seed;
        bus.in_sign   = sg;
        bus.in_mag    = mag;
        bus.out_ready = ordy;
    endtask

    // Drive on the falling edge, let one rising edge pass, sample 1 unit later.
    task automatic cycle(input logic v, input logic ld, input logic [7:0] seed,
                         input logic sg, input logic [8:0] mag, input logic ordy);
        @(negedge clk);
        drive(v, ld, seed, sg, mag, ordy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 1'b0, 9'd0, 1'b1);

        //          v  ld seed  sg mag  ordy rdy ov data sat idx err
        vecs[0]  = mk(1, 0, 0,   0, 7,   1,   1,  0, 0,   0,  0,  1);
        vecs[1]  = mk(0, 0, 0,   0, 0,   1,   1,  0, 0,   0,  0,  0);
        vecs[2]  = mk(1, 1, 40,  0, 0,   1,   1,  1, 40,  0,  0,  0);
        vecs[3]  = mk(1, 1, 100, 0, 0,   1,   1,  1, 100, 0,  0,  0);
        vecs[4]  = mk(1, 0, 0,   0, 20,  1,   1,  1, 120, 0,  1,  0);
        vecs[5]  = mk(1, 0, 0,   1, 50,  1,   1,  1, 70,  0,  2,  0);
        vecs[6]  = mk(1, 0, 0,   1, 3,   1,   1,  1, 67,  0,  3,  0);
        vecs[7]  = mk(1, 1, 10,  0, 0,   1,   1,  1, 10,  0,  0,  0);
        vecs[8]  = mk(1, 0, 0,   1, 30,  1,   1,  1, 0,   1,  1,  0);
        vecs[9]  = mk(1, 0, 0,   0, 5,   1,   1,  1, 5,   0,  2,  0);
        vecs[10] = mk(1, 1, 250, 0, 0,   1,   1,  1, 250, 0,  0,  0);
        vecs[11] = mk(1, 0, 0,   0, 300, 1,   1,  1, 255, 1,  1,  0);
        vecs[12] = mk(1, 0, 0,   0, 511, 1,   1,  1, 255, 1,  2,  0);
        vecs[13] = mk(1, 0, 0,   1, 511, 1,   1,  1, 0,   1,  3,  0);
        vecs[14] = mk(1, 1, 5,   1, 500, 1,   1,  1, 5,   0,  0,  0);
        vecs[15] = mk(0, 0, 0,   0, 0,   1,   1,  0, 0,   0,  0,  0);
        vecs[16] = mk(1, 0, 0,   0, 1,   0,   1,  1, 6,   0,  1,  0);
        vecs[17] = mk(1, 0, 0,   0, 1,   0,   0,  1, 6,   0,  1,  0);
        vecs[18] = mk(1, 0, 0,   0, 1,   0,   0,  1, 6,   0,  1,  0);
        vecs[19] = mk(1, 0, 0,   0, 1,   0,   0,  1, 6,   0,  1,  0);
        vecs[20] = mk(1, 0, 0,   0, 1,   0,   0,  1, 6,   0,  1,  0);
        vecs[21] = mk(1, 0, 0,   0, 1,   1,   1,  1, 7,   0,  2,  0);
        vecs[22] = mk(1, 0, 0,   0, 2,   1,   1,  1, 9,   0,  3,  0);
        vecs[23] = mk(0, 0, 0,   0, 0,   0,   0,  1, 9,   0,  3,  0);
        vecs[24] = mk(0, 0, 0,   0, 0,   1,   1,  0, 0,   0,  0,  0);
        vecs[25] = mk(0, 1, 77,  0, 0,   1,   1,  0, 0,   0,  0,  0);
        vecs[26] = mk(1, 0, 0,   0, 1,   1,   1,  1, 10,  0,  4,  0);

        // Reset held for two cycles
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_out_data", {24'd0, bus.out_data}, 0);
        check("rst_out_sat", {31'd0, bus.out_sat}, 0);
        check("rst_out_idx", {24'd0, bus.out_idx}, 0);
        check("rst_err", {31'd0, bus.err_noseed}, 0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].ld, vecs[i].seed, vecs[i].sg, vecs[i].mag, vecs[i].ordy);
            #1;
            check($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].e_ov});
            check($sformatf("v%0d_err", i), {31'd0, bus.err_noseed}, {31'd0, vecs[i].e_err});
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d_data", i), {24'd0, bus.out_data}, {24'd0, vecs[i].e_data});
                check($sformatf("v%0d_sat", i), {31'd0, bus.out_sat}, {31'd0, vecs[i].e_sat});
                check($sformatf("v%0d_idx", i), {24'd0, bus.out_idx}, {24'd0, vecs[i].e_idx});
            end
        end

        // Index wrap: seed then 256 zero deltas
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 1'b0, 9'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b1, 8'd33, 1'b0, 9'd0, 1'b1);
        check("wrap_seed_idx", {24'd0, bus.out_idx}, 0);
        for (int k = 1; k <= 256; k++) begin
            cycle(1'b1, 1'b0, 8'd0, 1'b0, 9'd0, 1'b1);
            check($sformatf("wrap_idx_%0d", k), {24'd0, bus.out_idx}, k % 256);
        end
        check("wrap_data", {24'd0, bus.out_data}, 33);
        check("wrap_valid", {31'd0, bus.out_valid}, 1);

        // Reset while a sample is stalled downstream
        cycle(1'b1, 1'b1, 8'd50, 1'b0, 9'd0, 1'b0);
        check("stall_valid", {31'd0, bus.out_valid}, 1);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'd0, 1'b0, 9'd1, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_valid", {31'd0, bus.out_valid}, 0);
        check("midrst_data", {24'd0, bus.out_data}, 0);
        check("midrst_idx", {24'd0, bus.out_idx}, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'd0, 1'b0, 9'd7, 1'b1);
        @(posedge clk);
        #1;
        check("midrst_noseed_err", {31'd0, bus.err_noseed}, 1);
        check("midrst_noseed_valid", {31'd0, bus.out_valid}, 0);
        cycle(1'b0, 1'b0, 8'd0, 1'b0, 9'd0, 1'b1);
        check("midrst_err_pulse", {31'd0, bus.err_noseed}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
